// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding and timer sizing for the PLL lock supervisor
package pll_sup_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    // One timer serves every state, so it is sized for the longest interval it has to count.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer with synchronous active-low reset
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; the last flop is the clean copy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock supervisor, optional lock-loss glitch filter via PLL_LOCK_GLITCH_FILTER_EN
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RESET_CYCLES = 48,
    parameter int LOCK_TIMEOUT     = 480000,
    parameter int STABLE_CYCLES    = 4800,
    parameter int MAX_RETRIES      = 8,
    parameter int CNT_W            = 8
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    ,
    parameter int GLITCH_CYCLES    = 4
`endif
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             retry,
    input  logic             clear_counts,
    output logic             pll_resetb,
    output logic             sys_reset_n,
    output logic             fault,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       state
);

    localparam int TW = timer_width(PLL_RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0]    RESET_LAST   = TW'(PLL_RESET_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LIMIT  = CNT_W'(MAX_RETRIES);

    pll_state_t       cur_state;
    logic [TW-1:0]    timer;
    logic             locked_s;
    logic             loss;
    logic [CNT_W-1:0] retry_next;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clock_in),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    assign retry_next = retry_count + CNT_W'(1);
    assign state      = cur_state;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int LW = (GLITCH_CYCLES > 2) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [LW-1:0] LOW_LAST = LW'(GLITCH_CYCLES - 1);

    logic [LW-1:0] low_run;

    // Count preceding consecutive low cycles of locked_s, saturating at the loss threshold.
    always_ff @(posedge clock_in) begin
        if (!reset_n || locked_s) begin
            low_run <= '0;
        end else if (low_run != LOW_LAST) begin
            low_run <= low_run + LW'(1);
        end
    end

    assign loss = !locked_s && (low_run == LOW_LAST);
`else
    assign loss = !locked_s;
`endif

    // Acquisition FSM; outputs are updated on the same edge as the transition that changes them.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            cur_state   <= PLL_RESET;
            timer       <= '0;
            pll_resetb  <= 1'b0;
            sys_reset_n <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            case (cur_state)
                PLL_RESET: begin
                    if (timer == RESET_LAST) begin
                        cur_state  <= WAIT_LOCK;
                        timer      <= '0;
                        pll_resetb <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still counts as a successful acquisition.
                    if (locked_s) begin
                        cur_state <= STABLE;
                        timer     <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer       <= '0;
                        retry_count <= retry_next;
                        pll_resetb  <= 1'b0;
                        if (retry_next == RETRY_LIMIT) begin
                            cur_state <= FAULT;
                            fault     <= 1'b1;
                        end else begin
                            cur_state <= PLL_RESET;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STABLE: begin
                    // Lock dropping before the stable interval is not a loss event, just a new wait.
                    if (!locked_s) begin
                        cur_state <= WAIT_LOCK;
                        timer     <= '0;
                    end else if (timer == STABLE_LAST) begin
                        cur_state   <= RUN;
                        timer       <= '0;
                        sys_reset_n <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RUN: begin
                    if (loss) begin
                        cur_state   <= PLL_RESET;
                        timer       <= '0;
                        pll_resetb  <= 1'b0;
                        sys_reset_n <= 1'b0;
                        retry_count <= '0;
                        if (loss_count != '1) begin
                            loss_count <= loss_count + CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (retry) begin
                        cur_state   <= PLL_RESET;
                        timer       <= '0;
                        fault       <= 1'b0;
                        retry_count <= '0;
                    end
                end
                default: begin
                    cur_state   <= PLL_RESET;
                    timer       <= '0;
                    pll_resetb  <= 1'b0;
                    sys_reset_n <= 1'b0;
                    fault       <= 1'b0;
                end
            endcase
            // Clearing wins over an increment landing on the same edge.
            if (clear_counts) begin
                loss_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int SS  = 2;
    localparam int PRC = 4;
    localparam int LT  = 20;
    localparam int SC  = 10;
    localparam int MR  = 3;
    localparam int CW  = 8;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int GC       = 4;
    localparam int LOSS_LAT = SS + GC - 1;
    localparam int MIN_DROP = GC;
`else
    localparam int LOSS_LAT = SS;
    localparam int MIN_DROP = 1;
`endif

    logic          clock_in = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          retry = 1'b0;
    logic          clear_counts = 1'b0;
    logic          pll_resetb;
    logic          sys_reset_n;
    logic          fault;
    logic [CW-1:0] retry_count;
    logic [CW-1:0] loss_count;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_lc = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES      (SS),
        .PLL_RESET_CYCLES (PRC),
        .LOCK_TIMEOUT     (LT),
        .STABLE_CYCLES    (SC),
        .MAX_RETRIES      (MR),
        .CNT_W            (CW)
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        ,
        .GLITCH_CYCLES    (GC)
`endif
    ) dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .retry        (retry),
        .clear_counts (clear_counts),
        .pll_resetb   (pll_resetb),
        .sys_reset_n  (sys_reset_n),
        .fault        (fault),
        .retry_count  (retry_count),
        .loss_count   (loss_count),
        .state        (state)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_resetb;
            1:       return sys_reset_n;
            default: return fault;
        endcase
    endfunction

    // Step until the selected output reaches val; the edge it happened on must be exp_edge.
    task automatic wait_for(input string tag, input int sel, input logic val, input int bound, input int exp_edge);
        int n;
        n = 0;
        while (sig(sel) !== val && n < bound) begin
            step();
            n++;
        end
        check(tag, (sig(sel) === val) ? cyc : -1, exp_edge);
    endtask

    // From RUN: hold pll_locked low for L sampling edges, then high; check loss and re-acquisition timing.
    task automatic loss_event(input string tag, input int L, input bit clr, input int exp_loss);
        int k, f, stab, fall_e, prb_e, rise_e;
        logic [CW-1:0] lc_at_fall;
        logic [2:0]    st_at_fall;
        fall_e = -1; prb_e = -1; rise_e = -1;
        lc_at_fall = '0; st_at_fall = '0;
        pll_locked = 1'b0;
        k = cyc + 1;
        f = k + LOSS_LAT;
        stab = (f + PRC + 1 > k + L + SS) ? f + PRC + 1 : k + L + SS;
        for (int n = 0; n < 150 && rise_e < 0; n++) begin
            step();
            if (cyc == k + L - 1) pll_locked = 1'b1;
            if (clr && cyc == f - 1) clear_counts = 1'b1;
            if (cyc == f) clear_counts = 1'b0;
            if (fall_e < 0 && sys_reset_n === 1'b0) begin
                fall_e = cyc;
                lc_at_fall = loss_count;
                st_at_fall = state;
            end else if (fall_e >= 0 && prb_e < 0 && pll_resetb === 1'b1) begin
                prb_e = cyc;
            end
            if (fall_e >= 0 && sys_reset_n === 1'b1) rise_e = cyc;
        end
        clear_counts = 1'b0;
        check($sformatf("%s_fall_edge", tag), fall_e, f);
        check($sformatf("%s_loss_count", tag), lc_at_fall, exp_loss);
        check($sformatf("%s_state_after_loss", tag), st_at_fall, 0);
        check($sformatf("%s_resetb_rise", tag), prb_e, f + PRC);
        check($sformatf("%s_rise_edge", tag), rise_e, stab + SC);
        check($sformatf("%s_retry_count", tag), retry_count, 0);
    endtask

    initial begin
        int base, w, k, r, f, s, L5, rise_e, bad;
        bit fall_seen;
        logic [2:0] st5, st6;

        // Reset values
        repeat (3) step();
        check("rst_pll_resetb", pll_resetb, 0);
        check("rst_sys_reset_n", sys_reset_n, 0);
        check("rst_fault", fault, 0);
        check("rst_retry_count", retry_count, 0);
        check("rst_loss_count", loss_count, 0);
        check("rst_state", state, 0);

        // Scenario 1: first acquisition
        reset_n = 1'b1;
        base = cyc;
        wait_for("s1_resetb_rise", 0, 1'b1, 20, base + PRC);
        w = cyc;
        step();
        step();
        pll_locked = 1'b1;
        k = cyc + 1;
        wait_for("s1_sys_rise", 1, 1'b1, 60, k + SS + SC);
        check("s1_retry_count", retry_count, 0);
        check("s1_state_run", state, 3);
        check("s1_resetb_high", pll_resetb, 1);

        // retry outside FAULT does nothing
        retry = 1'b1;
        step();
        retry = 1'b0;
        check("retry_ignored_state", state, 3);
        check("retry_ignored_fault", fault, 0);

        // Scenario 4: loss in RUN
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        pll_locked = 1'b0;
        repeat (GC - 1) step();
        pll_locked = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (sys_reset_n !== 1'b1) bad++;
        end
        check("s4_short_glitch_low_cycles", bad, 0);
        check("s4_short_glitch_loss_count", loss_count, 0);
        check("s4_short_glitch_state", state, 3);
`endif
        exp_lc = 1;
        loss_event("s4", MIN_DROP, 1'b0, exp_lc);

        // Scenario 5: lock drops in STABLE at timer 5
        L5 = MIN_DROP;
        pll_locked = 1'b0;
        k = cyc + 1;
        f = k + LOSS_LAT;
        s = f + PRC + 1;
        fall_seen = 1'b0;
        rise_e = -1;
        st5 = '0;
        st6 = '0;
        for (int n = 0; n < 120 && rise_e < 0; n++) begin
            step();
            if (cyc == k + L5 - 1) pll_locked = 1'b1;
            if (cyc == s + 3) pll_locked = 1'b0;
            if (cyc == s + 6) pll_locked = 1'b1;
            if (cyc == s + 5) st5 = state;
            if (cyc == s + 6) st6 = state;
            if (!fall_seen && sys_reset_n === 1'b0) fall_seen = 1'b1;
            else if (fall_seen && sys_reset_n === 1'b1) rise_e = cyc;
        end
        exp_lc = 2;
        check("s5_state_stable", st5, 2);
        check("s5_state_back_to_wait", st6, 1);
        check("s5_rise_after_restart", rise_e, s + 9 + SC);
        check("s5_loss_count", loss_count, exp_lc);

        // Randomized loss / re-acquisition series; loss_count must saturate
        for (int i = 0; i < 300; i++) begin
            int L;
            L = int'($urandom_range(20, MIN_DROP));
            exp_lc = (exp_lc < 255) ? exp_lc + 1 : 255;
            loss_event($sformatf("rand%0d", i), L, 1'b0, exp_lc);
        end
        check("s6_saturated", loss_count, 255);

        // Scenario 6: clear_counts coincident with a loss at 0xFF
        loss_event("s6_clear", MIN_DROP, 1'b1, 0);
        check("s6_cleared_after", loss_count, 0);

        // Mid-operation reset restores reset values
        step();
        reset_n = 1'b0;
        pll_locked = 1'b0;
        step();
        check("midrst_state", state, 0);
        check("midrst_sys_reset_n", sys_reset_n, 0);
        check("midrst_pll_resetb", pll_resetb, 0);

        // Scenario 2: no lock -> retries then FAULT
        step();
        reset_n = 1'b1;
        base = cyc;
        wait_for("s2_rise1", 0, 1'b1, 20, base + PRC);
        w = cyc;
        wait_for("s2_fall1", 0, 1'b0, 40, w + LT);
        check("s2_retry1", retry_count, 1);
        wait_for("s2_rise2", 0, 1'b1, 20, w + LT + PRC);
        wait_for("s2_fall2", 0, 1'b0, 40, w + 2 * LT + PRC);
        check("s2_retry2", retry_count, 2);
        wait_for("s2_rise3", 0, 1'b1, 20, w + 2 * LT + 2 * PRC);
        wait_for("s2_fault", 2, 1'b1, 40, w + 3 * LT + 2 * PRC);
        check("s2_retry3", retry_count, MR);
        check("s2_state_fault", state, 4);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pll_resetb !== 1'b0 || state !== 3'd4) bad++;
        end
        check("s2_fault_hold", bad, 0);

        // Scenario 3: retry from FAULT; lock arrives exactly on the timeout cycle
        retry = 1'b1;
        step();
        retry = 1'b0;
        r = cyc;
        check("s3_fault_cleared", fault, 0);
        check("s3_retry_count", retry_count, 0);
        check("s3_state", state, 0);
        repeat (LT + PRC - 3) step();
        pll_locked = 1'b1;
        wait_for("s3_sys_rise", 1, 1'b1, 60, r + PRC + LT + SC);
        check("s3_lock_priority_retry", retry_count, 0);
        check("s3_state_run", state, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
